// File: rtl/shared_reg_arbiter_pkg.sv
// Shared constants, FSM encodings and helpers for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;

   localparam int unsigned DefNReq  = 4;
   localparam int unsigned DefWidth = 8;
   localparam int unsigned WrCountW = 16;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StOwn  = 1'b1;

   // Owner index width, never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_reg_bank_dff.sv
// WIDTH-wide storage register with load enable and asynchronous active-low clear.
module reg_bank_dff #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             RSTN,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         q_q <= '0;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter committing one requester's data per grant into a shared register.
// Optional hold-grant behaviour is enabled by defining ARB_LOCK_EN.
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic                            clk,
   input  logic                            RSTN,
   input  logic [N_REQ-1:0]                req_i,
   input  logic [N_REQ*WIDTH-1:0]          wdata_i,
   input  logic [N_REQ-1:0]                lock_i,
   output logic [N_REQ-1:0]                gnt_o,
   output logic [WIDTH-1:0]                q_o,
   output logic                            q_valid_o,
   output logic [idx_width(N_REQ)-1:0]     owner_id_o,
   output logic [WrCountW-1:0]             wr_count_o
);

   localparam int unsigned IdxW = idx_width(N_REQ);

   logic [0:0]          state_q, state_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [IdxW-1:0]     own_q, own_d;
   logic [IdxW-1:0]     ptr_q, ptr_d;
   logic [IdxW-1:0]     owner_id_q;
   logic                q_valid_q;
   logic [WrCountW-1:0] wr_count_q;

   logic                commit;
   logic                hold;
   logic [IdxW-1:0]     pick;
   logic                found;
   int unsigned         idx;
   logic [WIDTH-1:0]    wslice [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign wslice[g] = wdata_i[g*WIDTH +: WIDTH];
   end

   // First set request at or above the pointer, wrapping modulo N_REQ.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (32'(ptr_q) + i) % N_REQ;
         if (!found && req_i[IdxW'(idx)]) begin
            found = 1'b1;
            pick  = IdxW'(idx);
         end
      end
   end

`ifdef ARB_LOCK_EN
   assign hold = commit && |(lock_i & gnt_q);
`else
   logic unused_lock;
   assign unused_lock = ^lock_i;
   assign hold        = 1'b0;
`endif

   // gnt_q is one-hot of the owner while in StOwn, so masking req selects the owner's bit.
   assign commit = (state_q == StOwn) && |(req_i & gnt_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      case (state_q)
         StIdle: begin
            gnt_d = '0;
            if (found) begin
               state_d = StOwn;
               own_d   = pick;
               gnt_d   = N_REQ'(1) << pick;
            end
         end
         StOwn: begin
            if (!hold) begin
               state_d = StIdle;
               gnt_d   = '0;
               ptr_d   = (own_q == IdxW'(N_REQ - 1)) ? '0 : own_q + IdxW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         own_q      <= '0;
         ptr_q      <= '0;
         owner_id_q <= '0;
         q_valid_q  <= 1'b0;
         wr_count_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         own_q   <= own_d;
         ptr_q   <= ptr_d;
         if (commit) begin
            owner_id_q <= own_q;
            q_valid_q  <= 1'b1;
            wr_count_q <= wr_count_q + WrCountW'(1);
         end
      end
   end

   reg_bank_dff #(
      .WIDTH(WIDTH)
   ) u_reg_bank (
      .clk  (clk),
      .RSTN (RSTN),
      .en_i (commit),
      .d_i  (wslice[own_q]),
      .q_o  (q_o)
   );

   assign gnt_o      = gnt_q;
   assign q_valid_o  = q_valid_q;
   assign owner_id_o = owner_id_q;
   assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, single grant, fairness, abandon, lock, wrap.
module tb_shared_reg_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   logic          clk = 1'b0;
   logic          RSTN;
   logic [N-1:0]  req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]  lock;
   logic [N-1:0]  gnt;
   logic [W-1:0]  q;
   logic          q_valid;
   logic [1:0]    owner_id;
   logic [15:0]   wr_count;

   int checks = 0;
   int passed = 0;
   int exp_cnt;

   always #5 clk = ~clk;

   shared_reg_arbiter #(
      .N_REQ(N),
      .WIDTH(W)
   ) dut (
      .clk        (clk),
      .RSTN       (RSTN),
      .req_i      (req),
      .wdata_i    (wdata),
      .lock_i     (lock),
      .gnt_o      (gnt),
      .q_o        (q),
      .q_valid_o  (q_valid),
      .owner_id_o (owner_id),
      .wr_count_o (wr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic put(input int i, input logic [7:0] v);
      wdata = (wdata & ~(32'hFF << (i * 8))) | (32'(v) << (i * 8));
   endtask

   initial begin
      RSTN  = 1'b0;
      req   = '0;
      lock  = '0;
      wdata = '0;
      #12;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_q", 32'(q), 0);
      chk("rst_valid", 32'(q_valid), 0);
      chk("rst_cnt", 32'(wr_count), 0);
      chk("rst_owner", 32'(owner_id), 0);
      @(negedge clk) RSTN = 1'b1;

      // Single request from requester 2
      @(negedge clk);
      req = 4'b0100;
      put(2, 8'hA5);
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_cnt_pre", 32'(wr_count), 0);
      @(negedge clk);
      chk("single_q", 32'(q), 32'hA5);
      chk("single_owner", 32'(owner_id), 2);
      chk("single_cnt", 32'(wr_count), 1);
      chk("single_valid", 32'(q_valid), 1);
      chk("single_gnt_off", 32'(gnt), 0);
      req = 4'b1111;

      // Pointer is 3, so requester 3 is granted; reset lands mid-OWN
      @(negedge clk);
      chk("rstmid_gnt_pre", 32'(gnt), 32'h8);
      #2 RSTN = 1'b0;
      #1;
      chk("rstmid_gnt", 32'(gnt), 0);
      chk("rstmid_q", 32'(q), 0);
      chk("rstmid_valid", 32'(q_valid), 0);
      chk("rstmid_cnt", 32'(wr_count), 0);
      chk("rstmid_owner", 32'(owner_id), 0);

      // Fairness with all requesters held
      @(negedge clk);
      RSTN = 1'b1;
      for (int i = 0; i < 4; i++) put(i, 8'(8'h10 + i));
      for (int r = 0; r < 5; r++) begin
         @(negedge clk);
         chk($sformatf("fair_gnt%0d", r), 32'(gnt), 32'(1) << (r % 4));
         @(negedge clk);
         chk($sformatf("fair_q%0d", r), 32'(q), 32'(8'h10 + (r % 4)));
         chk($sformatf("fair_owner%0d", r), 32'(owner_id), 32'(r % 4));
         chk($sformatf("fair_idle%0d", r), 32'(gnt), 0);
      end
      chk("fair_cnt", 32'(wr_count), 5);
      req = '0;

      // Abandon: requester 1 drops in its grant cycle
      @(negedge clk);
      req = 4'b0010;
      put(1, 8'h77);
      @(negedge clk);
      chk("abandon_gnt", 32'(gnt), 32'h2);
      req = '0;
      @(negedge clk);
      chk("abandon_q", 32'(q), 32'h10);
      chk("abandon_cnt", 32'(wr_count), 5);
      chk("abandon_gnt_off", 32'(gnt), 0);
      req = 4'b1111;
      @(negedge clk);
      chk("abandon_next_gnt", 32'(gnt), 32'h4);
      @(negedge clk);
      chk("abandon_next_q", 32'(q), 32'h12);
      chk("abandon_next_cnt", 32'(wr_count), 6);
      req  = 4'b1000;
      lock = 4'b1000;
      put(3, 8'h01);
      @(negedge clk);
      chk("lock_gnt", 32'(gnt), 32'h8);

`ifdef ARB_LOCK_EN
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("lock_q%0d", k), 32'(q), 32'(k));
         chk($sformatf("lock_hold%0d", k), 32'(gnt), 32'h8);
         put(3, 8'(k + 1));
         if (k == 3) lock = '0;
      end
      @(negedge clk);
      chk("lock_q4", 32'(q), 32'h4);
      chk("lock_gnt_off", 32'(gnt), 0);
      exp_cnt = 10;
`else
      @(negedge clk);
      chk("nolock_q", 32'(q), 32'h1);
      chk("nolock_gnt_off", 32'(gnt), 0);
      exp_cnt = 7;
`endif
      chk("lock_cnt", 32'(wr_count), 32'(exp_cnt));
      req  = 4'b1111;
      lock = '0;
      @(negedge clk);
      chk("after_lock_gnt", 32'(gnt), 32'h1);
      req = '0;
      @(negedge clk);
      chk("after_lock_cnt", 32'(wr_count), 32'(exp_cnt));

      // Counter wrap
      force dut.wr_count_q = 16'hFFFF;
      #1 release dut.wr_count_q;
      #1;
      chk("wrap_preset", 32'(wr_count), 32'hFFFF);
      req = 4'b0010;
      put(1, 8'h5A);
      @(negedge clk);
      chk("wrap_gnt", 32'(gnt), 32'h2);
      @(negedge clk);
      chk("wrap_cnt", 32'(wr_count), 0);
      chk("wrap_q", 32'(q), 32'h5A);
      chk("wrap_owner", 32'(owner_id), 1);
      chk("wrap_valid", 32'(q_valid), 1);
      req = '0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
